ls_control_unit: RTL and testbench

//  Moore control sequencer for the DataPath: fetch, decode and execute of ld, ldi, st, addi, andi, ori, nop, halt.

---
 rtl/minisrc_ctrl_pkg.sv | 43 ++++
 rtl/ls_control_unit_if.sv | 26 ++
 rtl/ctrl_mem_watchdog.sv | 24 ++
 rtl/ls_control_unit.sv | 129 ++++++++++++
 tb/tb_ls_control_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minisrc_ctrl_pkg.sv
// Opcodes, ALU operation codes, FSM states and control-word layout shared by the
// load/store control sequencer.
package minisrc_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [5:0] ALU_ADD = 6'd4;
  localparam logic [5:0] ALU_AND = 6'd5;
  localparam logic [5:0] ALU_OR  = 6'd6;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC, S_A0, S_A1, S_A2,
    S_L0, S_L1, S_L2, S_S1, S_S2, S_W0, S_HALT
  } state_e;

  typedef struct packed {
    logic PCout, IRout, RYout, RZLOout, RZHIout, MARout, Immout, MDRout;
    logic PCin, IRin, RYin, RZin, MARin, MDRin;
    logic Read, Write, IncPC, Gra, Grb, Grc, Rout, Rin, BAout, start;
    logic run;
  } ctl_t;

  function automatic logic [5:0] alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Base-addressed forms read R0 as zero through BAout.
  function automatic logic uses_base(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/ls_control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath/memory/ALU (slave).
interface ls_control_unit_if #(parameter int OPSEL_W = 6);
  logic [31:0]        IR;
  logic               finished, memFinished;
  logic               PCout, IRout, RYout, RZLOout, RZHIout, MARout, Immout, MDRout;
  logic               PCin, IRin, RYin, RZin, MARin, MDRin;
  logic               Read, Write, IncPC, Gra, Grb, Grc, Rout, Rin, BAout, start;
  logic [OPSEL_W-1:0] opSelect;
  logic               run, memErr;

  modport master (
    input  IR, finished, memFinished,
    output PCout, IRout, RYout, RZLOout, RZHIout, MARout, Immout, MDRout,
           PCin, IRin, RYin, RZin, MARin, MDRin,
           Read, Write, IncPC, Gra, Grb, Grc, Rout, Rin, BAout, start,
           opSelect, run, memErr
  );

  modport slave (
    output IR, finished, memFinished,
    input  PCout, IRout, RYout, RZLOout, RZHIout, MARout, Immout, MDRout,
           PCin, IRin, RYin, RZin, MARin, MDRin,
           Read, Write, IncPC, Gra, Grb, Grc, Rout, Rin, BAout, start,
           opSelect, run, memErr
  );
endinterface

// File: rtl/ctrl_mem_watchdog.sv
// Memory wait watchdog: counts cycles spent in a wait state; expired marks the last
// permitted cycle. TIMEOUT of 0 never expires.
module ctrl_mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && en && (cnt == LAST);
endmodule

// File: rtl/ls_control_unit.sv
// Moore fetch/decode/execute sequencer for ld, ldi, st, addi, andi, ori, nop, halt.
// Outputs are registered from the next state, so they always equal a decode of the state.
module ls_control_unit
  import minisrc_ctrl_pkg::*;
#(
  parameter int OPSEL_W     = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               Clock,
  input logic               clear,
  ls_control_unit_if.master bus
);
  state_e             state, nxt;
  ctl_t               ctl;
  logic [OPSEL_W-1:0] opsel;
  logic               mem_err;
  logic [4:0]         op_q, op_nxt;
  logic               in_wait, wd_expired, wd_trip;
  logic               ir_unused;

  // Opcode is captured in DEC so IR is only observed there.
  assign op_nxt    = (state == S_DEC) ? bus.IR[31:27] : op_q;
  assign in_wait   = (state == S_F1) || (state == S_L1) || (state == S_S2);
  assign wd_trip   = in_wait && !bus.memFinished && wd_expired;
  assign ir_unused = ^bus.IR[26:0];

  ctrl_mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk     (Clock),
    .rst     (clear),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (wd_expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_RST:  nxt = S_F0;
      S_F0:   nxt = S_F1;
      S_F1:   if (bus.memFinished) nxt = S_F2; else if (wd_expired) nxt = S_HALT;
      S_F2:   nxt = S_DEC;
      S_DEC: begin
        case (op_nxt)
          OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: nxt = S_A0;
          OP_HALT: nxt = S_HALT;
          OP_NOP:  nxt = S_F0;
          default: nxt = S_F0;
        endcase
      end
      S_A0:   nxt = S_A1;
      S_A1:   nxt = S_A2;
      S_A2:   if (bus.finished) nxt = (op_q == OP_LD || op_q == OP_ST) ? S_L0 : S_W0;
      S_L0:   nxt = (op_q == OP_ST) ? S_S1 : S_L1;
      S_L1:   if (bus.memFinished) nxt = S_L2; else if (wd_expired) nxt = S_HALT;
      S_L2:   nxt = S_F0;
      S_S1:   nxt = S_S2;
      S_S2:   if (bus.memFinished) nxt = S_F0; else if (wd_expired) nxt = S_HALT;
      S_W0:   nxt = S_F0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  function automatic ctl_t decode(input state_e s, input logic [4:0] op);
    ctl_t c;
    c     = '0;
    c.run = (s != S_RST) && (s != S_HALT);
    case (s)
      S_F0: begin c.PCout = 1'b1; c.MARin = 1'b1; end
      S_F1: begin c.IncPC = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      S_F2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_A0: begin c.Grb = 1'b1; c.Rout = 1'b1; c.RYin = 1'b1; c.BAout = uses_base(op); end
      S_A1: begin c.Immout = 1'b1; c.RZin = 1'b1; c.start = 1'b1; end
      S_A2: begin c.Immout = 1'b1; c.RZin = 1'b1; end
      S_L0: begin c.RZLOout = 1'b1; c.MARin = 1'b1; end
      S_L1: begin c.Read = 1'b1; c.MDRin = 1'b1; end
      S_L2: begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
      S_S1: begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
      S_S2: begin c.Write = 1'b1; end
      S_W0: begin c.RZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state   <= S_RST;
      ctl     <= '0;
      opsel   <= '0;
      mem_err <= 1'b0;
      op_q    <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt, op_nxt);
      opsel <= (nxt == S_A1 || nxt == S_A2) ? OPSEL_W'(alu_op(op_nxt)) : '0;
      op_q  <= op_nxt;
      if (wd_trip) mem_err <= 1'b1;
    end
  end

  assign bus.PCout    = ctl.PCout;
  assign bus.IRout    = ctl.IRout;
  assign bus.RYout    = ctl.RYout;
  assign bus.RZLOout  = ctl.RZLOout;
  assign bus.RZHIout  = ctl.RZHIout;
  assign bus.MARout   = ctl.MARout;
  assign bus.Immout   = ctl.Immout;
  assign bus.MDRout   = ctl.MDRout;
  assign bus.PCin     = ctl.PCin;
  assign bus.IRin     = ctl.IRin;
  assign bus.RYin     = ctl.RYin;
  assign bus.RZin     = ctl.RZin;
  assign bus.MARin    = ctl.MARin;
  assign bus.MDRin    = ctl.MDRin;
  assign bus.Read     = ctl.Read;
  assign bus.Write    = ctl.Write;
  assign bus.IncPC    = ctl.IncPC;
  assign bus.Gra      = ctl.Gra;
  assign bus.Grb      = ctl.Grb;
  assign bus.Grc      = ctl.Grc;
  assign bus.Rout     = ctl.Rout;
  assign bus.Rin      = ctl.Rin;
  assign bus.BAout    = ctl.BAout;
  assign bus.start    = ctl.start;
  assign bus.run      = ctl.run;
  assign bus.opSelect = opsel;
  assign bus.memErr   = mem_err;
endmodule

// File: tb/tb_ls_control_unit.sv
// Bench for ls_control_unit: per-cycle expected control words queued per instruction
// and compared as the sequencer steps; responders emulate ALU and memory latency.
module tb_ls_control_unit;
  localparam logic [4:0] T_LD = 5'd0, T_LDI = 5'd1, T_ST = 5'd2, T_ADDI = 5'd12;
  localparam logic [4:0] T_ANDI = 5'd13, T_ORI = 5'd14, T_NOP = 5'd26, T_HALT = 5'd27;

  typedef enum {E_RST, E_F0, E_F1, E_F2, E_DEC, E_A0, E_A1, E_A2,
                E_L0, E_L1, E_L2, E_S1, E_S2, E_W0, E_HALT} exp_st_e;

  typedef struct packed {
    logic PCout, IRout, RYout, RZLOout, RZHIout, MARout, Immout, MDRout;
    logic PCin, IRin, RYin, RZin, MARin, MDRin;
    logic Read, Write, IncPC, Gra, Grb, Grc, Rout, Rin, BAout, start;
    logic run;
    logic [5:0] opSelect;
  } vec_t;

  typedef struct {
    exp_st_e     st;
    vec_t        v;
    logic [31:0] ir;
  } sb_t;

  logic Clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0, failures = 0;
  int   mem_delay = 1, alu_delay = 1;
  bit   data_stall = 1'b0;
  int   rw_cyc = 0, alu_cnt = 0;
  sb_t  sb[$];
  vec_t obs;

  ls_control_unit_if #(.OPSEL_W(6)) bus ();

  ls_control_unit #(.OPSEL_W(6), .MEM_TIMEOUT(15)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    obs = '0;
    obs.PCout = bus.PCout;   obs.IRout = bus.IRout;   obs.RYout = bus.RYout;
    obs.RZLOout = bus.RZLOout; obs.RZHIout = bus.RZHIout; obs.MARout = bus.MARout;
    obs.Immout = bus.Immout; obs.MDRout = bus.MDRout; obs.PCin = bus.PCin;
    obs.IRin = bus.IRin;     obs.RYin = bus.RYin;     obs.RZin = bus.RZin;
    obs.MARin = bus.MARin;   obs.MDRin = bus.MDRin;   obs.Read = bus.Read;
    obs.Write = bus.Write;   obs.IncPC = bus.IncPC;   obs.Gra = bus.Gra;
    obs.Grb = bus.Grb;       obs.Grc = bus.Grc;       obs.Rout = bus.Rout;
    obs.Rin = bus.Rin;       obs.BAout = bus.BAout;   obs.start = bus.start;
    obs.run = bus.run;       obs.opSelect = bus.opSelect;
  end

  // Memory answers mem_delay cycles after a request is first seen; the ALU answers
  // alu_delay cycles after start. data_stall withholds memFinished outside fetch.
  initial begin
    bus.memFinished = 1'b0;
    bus.finished    = 1'b0;
    forever begin
      @(negedge Clock);
      if (bus.Read || bus.Write) rw_cyc++; else rw_cyc = 0;
      bus.memFinished = (bus.Read || bus.Write) && (rw_cyc > mem_delay)
                        && !(data_stall && !bus.IncPC);
      if (bus.start) alu_cnt = 1; else if (alu_cnt != 0) alu_cnt++;
      bus.finished = (alu_cnt > alu_delay);
    end
  end

  function automatic logic [31:0] mkir(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [18:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [5:0] opsel_of(logic [4:0] op);
    if (op == T_ANDI) return 6'd5;
    if (op == T_ORI)  return 6'd6;
    return 6'd4;
  endfunction

  function automatic vec_t expv(exp_st_e s, logic [4:0] op);
    vec_t v;
    v = '0;
    v.run = (s != E_RST) && (s != E_HALT);
    case (s)
      E_F0: begin v.PCout = 1; v.MARin = 1; end
      E_F1: begin v.IncPC = 1; v.Read = 1; v.MDRin = 1; end
      E_F2: begin v.MDRout = 1; v.IRin = 1; end
      E_A0: begin v.Grb = 1; v.Rout = 1; v.RYin = 1; v.BAout = (op == T_LD || op == T_LDI || op == T_ST); end
      E_A1: begin v.Immout = 1; v.RZin = 1; v.start = 1; v.opSelect = opsel_of(op); end
      E_A2: begin v.Immout = 1; v.RZin = 1; v.opSelect = opsel_of(op); end
      E_L0: begin v.RZLOout = 1; v.MARin = 1; end
      E_L1: begin v.Read = 1; v.MDRin = 1; end
      E_L2: begin v.MDRout = 1; v.Gra = 1; v.Rin = 1; end
      E_S1: begin v.Gra = 1; v.Rout = 1; v.MDRin = 1; end
      E_S2: begin v.Write = 1; end
      E_W0: begin v.RZLOout = 1; v.Gra = 1; v.Rin = 1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(exp_st_e s, int n, logic [31:0] ir);
    sb_t e;
    for (int i = 0; i < n; i++) begin
      e.st = s; e.v = expv(s, ir[31:27]); e.ir = ir;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.IR = '0;
    clear  = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (obs !== vec_t'(0)) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++;
    if (bus.memErr !== 1'b0) begin failures++; $display("FAIL reset_memErr got=%b exp=0", bus.memErr); end
  endtask

  task automatic test_ld();
    sb_t e; int cyc = 0, starts = 0, f0_at = -1, l2_at = -1;
    logic [31:0] ir = mkir(T_LD, 4'd1, 4'd2, 19'd4);
    mem_delay = 1; alu_delay = 1; data_stall = 0;
    do_reset();
    push(E_F0, 1, ir); push(E_F1, 2, ir); push(E_F2, 1, ir); push(E_DEC, 1, ir);
    push(E_A0, 1, ir); push(E_A1, 1, ir); push(E_A2, 1, ir); push(E_L0, 1, ir);
    push(E_L1, 2, ir); push(E_L2, 1, ir); push(E_F0, 1, ir);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL ld_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      if (obs.start) starts++;
      if (obs.PCout && f0_at < 0) f0_at = cyc;
      if (obs.Rin && obs.MDRout && l2_at < 0) l2_at = cyc;
      cyc++;
    end
    checks++;
    if (starts !== 1) begin failures++; $display("FAIL ld_start_pulses got=%0d exp=1", starts); end
    checks++;
    if (l2_at - f0_at !== 11) begin failures++; $display("FAIL ld_f0_to_l2 got=%0d exp=11", l2_at - f0_at); end
  endtask

  task automatic test_ldi_nop();
    sb_t e; int cyc = 0, late_reads = 0, ba = 0;
    logic [31:0] ir1 = mkir(T_LDI, 4'd1, 4'd0, 19'd4);
    logic [31:0] ir2 = mkir(T_NOP, 4'd0, 4'd0, 19'd0);
    mem_delay = 1; alu_delay = 1; data_stall = 0;
    do_reset();
    push(E_F0, 1, ir1); push(E_F1, 2, ir1); push(E_F2, 1, ir1); push(E_DEC, 1, ir1);
    push(E_A0, 1, ir1); push(E_A1, 1, ir1); push(E_A2, 1, ir1); push(E_W0, 1, ir1);
    push(E_F0, 1, ir2); push(E_F1, 2, ir2); push(E_F2, 1, ir2); push(E_DEC, 1, ir2);
    push(E_F0, 1, ir2);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL ldi_nop_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      if (obs.Read && e.st != E_F1) late_reads++;
      if (obs.BAout) ba++;
      cyc++;
    end
    checks++;
    if (late_reads !== 0) begin failures++; $display("FAIL ldi_read_after_fetch got=%0d exp=0", late_reads); end
    checks++;
    if (ba !== 1) begin failures++; $display("FAIL ldi_baout_cycles got=%0d exp=1", ba); end
  endtask

  task automatic test_st();
    sb_t e; int cyc = 0, writes = 0;
    logic [31:0] ir = mkir(T_ST, 4'd3, 4'd2, 19'd8);
    mem_delay = 5; alu_delay = 1; data_stall = 0;
    do_reset();
    push(E_F0, 1, ir); push(E_F1, 6, ir); push(E_F2, 1, ir); push(E_DEC, 1, ir);
    push(E_A0, 1, ir); push(E_A1, 1, ir); push(E_A2, 1, ir); push(E_L0, 1, ir);
    push(E_S1, 1, ir); push(E_S2, 6, ir); push(E_F0, 1, ir);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL st_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      if (obs.Write) writes++;
      cyc++;
    end
    checks++;
    if (writes !== 6) begin failures++; $display("FAIL st_write_cycles got=%0d exp=6", writes); end
  endtask

  task automatic test_logic_ops();
    sb_t e; int cyc = 0, n_and = 0, n_or = 0;
    logic [31:0] ir1 = mkir(T_ANDI, 4'd4, 4'd5, 19'h0ff);
    logic [31:0] ir2 = mkir(T_ORI,  4'd6, 4'd7, 19'h100);
    mem_delay = 0; alu_delay = 3; data_stall = 0;
    do_reset();
    push(E_F0, 1, ir1); push(E_F1, 1, ir1); push(E_F2, 1, ir1); push(E_DEC, 1, ir1);
    push(E_A0, 1, ir1); push(E_A1, 1, ir1); push(E_A2, 3, ir1); push(E_W0, 1, ir1);
    push(E_F0, 1, ir2); push(E_F1, 1, ir2); push(E_F2, 1, ir2); push(E_DEC, 1, ir2);
    push(E_A0, 1, ir2); push(E_A1, 1, ir2); push(E_A2, 3, ir2); push(E_W0, 1, ir2);
    push(E_F0, 1, ir2);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL logic_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      if (obs.opSelect == 6'd5) n_and++;
      if (obs.opSelect == 6'd6) n_or++;
      cyc++;
    end
    checks++;
    if (n_and !== 4) begin failures++; $display("FAIL andi_opsel_cycles got=%0d exp=4", n_and); end
    checks++;
    if (n_or !== 4) begin failures++; $display("FAIL ori_opsel_cycles got=%0d exp=4", n_or); end
  endtask

  task automatic test_mem_timeout();
    sb_t e; int cyc = 0;
    logic [31:0] ir = mkir(T_LD, 4'd1, 4'd2, 19'd4);
    mem_delay = 1; alu_delay = 1; data_stall = 1;
    do_reset();
    push(E_F0, 1, ir); push(E_F1, 2, ir); push(E_F2, 1, ir); push(E_DEC, 1, ir);
    push(E_A0, 1, ir); push(E_A1, 1, ir); push(E_A2, 1, ir); push(E_L0, 1, ir);
    push(E_L1, 15, ir); push(E_HALT, 5, ir);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL timeout_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      cyc++;
    end
    checks++;
    if (bus.memErr !== 1'b1) begin failures++; $display("FAIL timeout_memErr_set got=%b exp=1", bus.memErr); end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (bus.memErr !== 1'b0) begin failures++; $display("FAIL timeout_memErr_clear got=%b exp=0", bus.memErr); end
    @(negedge Clock);
    clear = 1'b0;
    data_stall = 0;
  endtask

  task automatic test_clear_halt();
    sb_t e; int cyc = 0;
    logic [31:0] ir1 = mkir(T_ADDI, 4'd2, 4'd3, 19'd7);
    logic [31:0] ir2 = mkir(T_HALT, 4'd0, 4'd0, 19'd0);
    mem_delay = 0; alu_delay = 50; data_stall = 0;
    do_reset();
    push(E_F0, 1, ir1); push(E_F1, 1, ir1); push(E_F2, 1, ir1); push(E_DEC, 1, ir1);
    push(E_A0, 1, ir1); push(E_A1, 1, ir1); push(E_A2, 2, ir1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL clear_pre_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      cyc++;
    end
    // Mid-cycle clear: outputs must drop before any clock edge.
    #2 clear = 1'b1;
    #1;
    checks++;
    if (obs !== vec_t'(0)) begin failures++; $display("FAIL clear_async got=%h exp=0", obs); end
    @(negedge Clock);
    clear = 1'b0;
    push(E_F0, 1, ir2); push(E_F1, 1, ir2); push(E_F2, 1, ir2); push(E_DEC, 1, ir2);
    push(E_HALT, 4, ir2);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL halt_seq cyc=%0d state=%s got=%h exp=%h", cyc, e.st.name(), obs, e.v); end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_ldi_nop();
    test_st();
    test_logic_ops();
    test_mem_timeout();
    test_clear_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
